// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: moves the registers selected by a mask to/from consecutive memory words.
// Optional macro SEQ_WRAP_ERR_EN: abort a burst with a sticky err instead of wrapping the address.
module lm_sm_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        reg_mask,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic [2:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen
);

  typedef enum logic [1:0] {StIdle, StXfer, StFin} state_e;

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [7:0]          mask_q, mask_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [2:0]          rf_raddr_q, rf_raddr_d;
  logic [2:0]          rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                rf_wen_q, rf_wen_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
`ifdef SEQ_WRAP_ERR_EN
  logic                err_q, err_d;
`endif

  logic                issue;
  logic                wrap_abort;
  logic [7:0]          src_mask;
  logic [2:0]          nxt_idx;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    mask_d      = mask_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = 1'b1;
    mem_write_d = 1'b1;
    rf_raddr_d  = rf_raddr_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wen_d    = 1'b0;
    done_d      = 1'b0;
`ifdef SEQ_WRAP_ERR_EN
    err_d       = err_q;
    wrap_abort  = (mem_addr_q == '1) && (mask_q != 8'd0);
`else
    wrap_abort  = 1'b0;
`endif
    issue       = 1'b0;
    src_mask    = (state_q == StIdle) ? reg_mask : mask_q;
    nxt_idx     = lowest_idx(src_mask);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dir_d = dir;
`ifdef SEQ_WRAP_ERR_EN
          err_d = 1'b0;
`endif
          if (reg_mask == 8'd0) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d    = StXfer;
            mem_addr_d = base_addr;
            issue      = 1'b1;
          end
        end
      end
      StXfer: begin
        // The closing edge of a load cycle captures memory data for next cycle's rf write.
        if (!dir_q) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = rf_raddr_q;
          rf_wdata_d = mem_out;
        end
        if ((mask_q == 8'd0) || wrap_abort) begin
          state_d = StFin;
          done_d  = 1'b1;
`ifdef SEQ_WRAP_ERR_EN
          if (wrap_abort) err_d = 1'b1;
`endif
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          issue      = 1'b1;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Set up the strobes and indices for the transfer occupying the next cycle.
    if (issue) begin
      mask_d      = src_mask & ~(8'd1 << nxt_idx);
      rf_raddr_d  = nxt_idx;
      if (dir_d) rf_waddr_d = nxt_idx;
      mem_read_d  = dir_d;
      mem_write_d = ~dir_d;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!proc_rst) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      mask_q      <= 8'd0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b1;
      rf_raddr_q  <= 3'd0;
      rf_waddr_q  <= 3'd0;
      rf_wdata_q  <= '0;
      rf_wen_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_WRAP_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      mask_q      <= mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rf_raddr_q  <= rf_raddr_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_wen_q    <= rf_wen_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef SEQ_WRAP_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wen    = rf_wen_q;
  assign mem_in    = ((state_q == StXfer) && dir_q) ? rf_rdata : '0;
`ifdef SEQ_WRAP_ERR_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: memory and register-file models plus a transfer-list
// reference model; honours SEQ_WRAP_ERR_EN when defined.
module tb_lm_sm_sequencer;
  localparam int AW   = 5;
  localparam int DW   = 16;
  localparam int NMEM = 1 << AW;
  localparam int LOGN = 11;
`ifdef SEQ_WRAP_ERR_EN
  localparam logic WrapErr = 1'b1;
`else
  localparam logic WrapErr = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          proc_rst = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    reg_mask = 8'd0;
  logic          busy, done, err, mem_read, mem_write, rf_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in, mem_out, rf_rdata, rf_wdata;
  logic [2:0]    rf_raddr, rf_waddr;

  always #5 clk = ~clk;

  lm_sm_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_rst(proc_rst), .start(start), .dir(dir), .base_addr(base_addr),
    .reg_mask(reg_mask), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_in(mem_in), .mem_out(mem_out),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wen(rf_wen)
  );

  // Memory and register-file environment models
  logic [DW-1:0] mem [NMEM];
  logic [DW-1:0] mem_seed [NMEM];
  logic [DW-1:0] rf [8];
  logic [DW-1:0] rf_seed [8];
  logic          load_seed = 1'b0;

  always @(posedge clk) begin
    if (load_seed) begin
      for (int i = 0; i < NMEM; i++) mem[i] <= mem_seed[i];
      for (int i = 0; i < 8; i++) rf[i] <= rf_seed[i];
    end else begin
      if (!mem_write) mem[mem_addr] <= mem_in;
      if (rf_wen) rf[rf_waddr] <= rf_wdata;
    end
  end
  always @(negedge clk) if (!mem_read) mem_out <= mem[mem_addr];
  assign rf_rdata = rf[rf_raddr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model results
  int            exp_n;
  logic          exp_err;
  logic [AW-1:0] exp_addr [8];
  logic [2:0]    exp_idx [8];
  logic [DW-1:0] mem_pre [NMEM];
  logic [DW-1:0] exp_mem [NMEM];
  logic [DW-1:0] rf_pre [8];
  logic [DW-1:0] exp_rf [8];

  // Per-cycle observations, index = cycles after the start-sampling edge
  logic          lg_rd [LOGN+1], lg_wr [LOGN+1], lg_wen [LOGN+1];
  logic          lg_done [LOGN+1], lg_busy [LOGN+1], lg_err [LOGN+1];
  logic [AW-1:0] lg_addr [LOGN+1];
  logic [2:0]    lg_raddr [LOGN+1], lg_waddr [LOGN+1];
  logic [DW-1:0] lg_min [LOGN+1], lg_wdata [LOGN+1];

  task automatic seed_env();
    for (int i = 0; i < NMEM; i++) mem_seed[i] = DW'($urandom);
    for (int i = 0; i < 8; i++) rf_seed[i] = DW'($urandom);
  endtask

  task automatic commit_seed();
    @(posedge clk); #1;
    load_seed = 1'b1;
    @(posedge clk); #1;
    load_seed = 1'b0;
  endtask

  // Transfers go to ascending set bits at consecutive (wrapping) addresses.
  task automatic model_burst(input logic d, input logic [AW-1:0] b, input logic [7:0] m);
    int   addr;
    logic stop;
    logic more;
    for (int i = 0; i < NMEM; i++) begin mem_pre[i] = mem[i]; exp_mem[i] = mem[i]; end
    for (int i = 0; i < 8; i++) begin rf_pre[i] = rf[i]; exp_rf[i] = rf[i]; end
    exp_n = 0; exp_err = 1'b0; stop = 1'b0; addr = int'(b);
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !stop) begin
        exp_addr[exp_n] = AW'(addr);
        exp_idx[exp_n]  = 3'(i);
        exp_n++;
        if (d) exp_mem[addr] = rf_pre[i];
        else   exp_rf[i] = mem_pre[addr];
        more = ((m >> (i + 1)) != 8'd0);
        if (WrapErr && addr == NMEM - 1 && more) begin
          stop = 1'b1;
          exp_err = 1'b1;
        end
        addr = (addr + 1) % NMEM;
      end
    end
  endtask

  task automatic test_burst(input logic d, input logic [AW-1:0] b, input logic [7:0] m);
    logic act, wen_exp;
    int   bad_at;
    model_burst(d, b, m);
    @(posedge clk); #1;
    start = 1'b1; dir = d; base_addr = b; reg_mask = m;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'($urandom); base_addr = AW'($urandom); reg_mask = 8'($urandom);
    for (int c = 1; c <= LOGN; c++) begin
      @(negedge clk);
      lg_rd[c] = mem_read;   lg_wr[c] = mem_write;  lg_addr[c] = mem_addr;
      lg_raddr[c] = rf_raddr; lg_min[c] = mem_in;   lg_wen[c] = rf_wen;
      lg_waddr[c] = rf_waddr; lg_wdata[c] = rf_wdata; lg_done[c] = done;
      lg_busy[c] = busy;     lg_err[c] = err;
      // A stray start while busy or in the done cycle must be ignored.
      if (c == 1) begin
        start = 1'b1; dir = 1'($urandom); reg_mask = 8'($urandom_range(1, 255));
      end
      if (c == 2) start = 1'b0;
    end
    for (int c = 1; c <= LOGN; c++) begin
      act = (c <= exp_n);
      n_checks++;
      if ({lg_rd[c], lg_wr[c]} !== {!(act && !d), !(act && d)}) begin
        n_fail++;
        $display("FAIL strobes cyc %0d: got rd=%b wr=%b, want rd=%b wr=%b", c, lg_rd[c],
                 lg_wr[c], !(act && !d), !(act && d));
      end
      if (act) begin
        n_checks++;
        if (lg_addr[c] !== exp_addr[c-1] || lg_raddr[c] !== exp_idx[c-1]) begin
          n_fail++;
          $display("FAIL xfer_addr cyc %0d: got addr=%0d idx=%0d, want addr=%0d idx=%0d", c,
                   lg_addr[c], lg_raddr[c], exp_addr[c-1], exp_idx[c-1]);
        end
        if (d) begin
          n_checks++;
          if (lg_min[c] !== rf_pre[exp_idx[c-1]]) begin
            n_fail++;
            $display("FAIL mem_in cyc %0d: got %h, want %h", c, lg_min[c], rf_pre[exp_idx[c-1]]);
          end
        end
      end
      n_checks++;
      if (lg_done[c] !== (c == exp_n + 1)) begin
        n_fail++;
        $display("FAIL done cyc %0d: got %b, want %b", c, lg_done[c], (c == exp_n + 1));
      end
      n_checks++;
      if (lg_busy[c] !== (c <= exp_n + 1)) begin
        n_fail++;
        $display("FAIL busy cyc %0d: got %b, want %b", c, lg_busy[c], (c <= exp_n + 1));
      end
      wen_exp = !d && (c >= 2) && (c <= exp_n + 1);
      n_checks++;
      if (lg_wen[c] !== wen_exp) begin
        n_fail++;
        $display("FAIL rf_wen cyc %0d: got %b, want %b", c, lg_wen[c], wen_exp);
      end
      if (wen_exp) begin
        n_checks++;
        if (lg_waddr[c] !== exp_idx[c-2] || lg_wdata[c] !== mem_pre[exp_addr[c-2]]) begin
          n_fail++;
          $display("FAIL rf_write cyc %0d: got r%0d=%h, want r%0d=%h", c, lg_waddr[c],
                   lg_wdata[c], exp_idx[c-2], mem_pre[exp_addr[c-2]]);
        end
      end
      n_checks++;
      if (lg_err[c] !== ((c >= exp_n + 1) ? exp_err : 1'b0)) begin
        n_fail++;
        $display("FAIL err cyc %0d: got %b, want %b", c, lg_err[c],
                 (c >= exp_n + 1) ? exp_err : 1'b0);
      end
    end
    bad_at = -1;
    for (int i = 0; i < NMEM; i++) if (bad_at < 0 && mem[i] !== exp_mem[i]) bad_at = i;
    n_checks++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL mem_final word %0d: got %h, want %h", bad_at, mem[bad_at], exp_mem[bad_at]);
    end
    bad_at = -1;
    for (int i = 0; i < 8; i++) if (bad_at < 0 && rf[i] !== exp_rf[i]) bad_at = i;
    n_checks++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL rf_final r%0d: got %h, want %h", bad_at, rf[bad_at], exp_rf[bad_at]);
    end
  endtask

  task automatic test_reset();
    proc_rst = 1'b0; start = 1'b1; reg_mask = 8'hFF;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, rf_wen, mem_read, mem_write} !== 6'b000011) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/done/err/wen/rd/wr=%b, want 000011",
               {busy, done, err, rf_wen, mem_read, mem_write});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_in !== '0 || rf_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h in=%h wdata=%h, want 0 0 0", mem_addr, mem_in, rf_wdata);
    end
    n_checks++;
    if (rf_raddr !== 3'd0 || rf_waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got raddr=%0d waddr=%0d, want 0 0", rf_raddr, rf_waddr);
    end
    proc_rst = 1'b1;
  endtask

  task automatic test_load();
    seed_env();
    for (int k = 0; k < 8; k++) mem_seed[2 + k] = DW'(k + 1);
    commit_seed();
    test_burst(1'b0, AW'(2), 8'hFF);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (rf[k] !== DW'(k + 1)) begin
        n_fail++;
        $display("FAIL load_r%0d: got %h, want %h", k, rf[k], DW'(k + 1));
      end
    end
  endtask

  task automatic test_store();
    seed_env();
    rf_seed[0] = 16'hAAAA; rf_seed[2] = 16'h5555; rf_seed[7] = 16'h1234;
    commit_seed();
    test_burst(1'b1, AW'(20), 8'b1000_0101);
    n_checks++;
    if ({mem[20], mem[21], mem[22]} !== {16'hAAAA, 16'h5555, 16'h1234}) begin
      n_fail++;
      $display("FAIL store_words: got %h %h %h, want aaaa 5555 1234", mem[20], mem[21], mem[22]);
    end
  endtask

  task automatic test_empty();
    seed_env();
    commit_seed();
    test_burst(1'b0, AW'($urandom_range(0, NMEM - 1)), 8'd0);
    test_burst(1'b1, AW'($urandom_range(0, NMEM - 1)), 8'd0);
  endtask

  task automatic test_wrap();
    seed_env();
    commit_seed();
    test_burst(1'b0, AW'(30), 8'h0F);
    n_checks++;
    if (err !== WrapErr) begin
      n_fail++;
      $display("FAIL wrap_err_load: got %b, want %b", err, WrapErr);
    end
    test_burst(1'b1, AW'(30), 8'h0F);
    n_checks++;
    if (err !== WrapErr) begin
      n_fail++;
      $display("FAIL wrap_err_store: got %b, want %b", err, WrapErr);
    end
    test_burst(1'b0, AW'(3), 8'h03);
  endtask

  task automatic test_reset_mid();
    seed_env();
    commit_seed();
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; base_addr = AW'(2); reg_mask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    proc_rst = 1'b0;
    @(negedge clk);
    proc_rst = 1'b1;
    n_checks++;
    if ({mem_read, mem_write, rf_wen, busy, done} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_mid: got rd/wr/wen/busy/done=%b, want 11000",
               {mem_read, mem_write, rf_wen, busy, done});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, rf_wen, busy} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_quiet +%0d: got rd/wr/wen/busy=%b, want 1100", c,
                 {mem_read, mem_write, rf_wen, busy});
      end
    end
    n_checks++;
    if ({rf[0], rf[1], rf[2]} !== {mem_seed[2], mem_seed[3], rf_seed[2]}) begin
      n_fail++;
      $display("FAIL reset_rf: got %h %h %h, want %h %h %h", rf[0], rf[1], rf[2],
               mem_seed[2], mem_seed[3], rf_seed[2]);
    end
    test_burst(1'b0, AW'(2), 8'hFF);
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int it = 0; it < 24; it++) begin
      seed_env();
      commit_seed();
      case (it % 6)
        0:       m = 8'd0;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      test_burst(1'($urandom_range(0, 1)), AW'($urandom_range(0, NMEM - 1)), m);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 5, memory word-address width; DATA_W, default 16, data word width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 proc_rst  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 dir  input  1  0 = load (memory to register file), 1 = store (register file to memory); sampled with start.
REQ-006 base_addr  input  ADDR_W  first memory address; sampled with start.
REQ-007 reg_mask  input  8  bit i set = transfer register i; sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  sticky wrap-abort flag (see Configuration).
REQ-011 mem_addr  output  ADDR_W  memory address.
REQ-012 mem_read  output  1  active-low read strobe.
REQ-013 mem_write  output  1  active-low write strobe.
REQ-014 mem_in  output  DATA_W  store data to memory.
REQ-015 mem_out  input  DATA_W  memory read data, updated by the memory on the falling edge within a strobed cycle.
REQ-016 rf_raddr  output  3  register-file read index; rf_rdata  input  DATA_W  combinational read data.
REQ-017 rf_waddr  output  3, rf_wdata  output  DATA_W, rf_wen  output  1  register-file write port, active-high.

Function
REQ-018 FSM SHALL have exactly the states IDLE, XFER and FIN.
REQ-019 IDLE with start=1: latch dir, base_addr and reg_mask; go to XFER, or to FIN if reg_mask=0.
REQ-020 XFER: each cycle, service the lowest remaining set mask bit i: drive rf_raddr/rf_waddr index = i and mem_addr = current address; clear bit i; increment address.
REQ-021 Load XFER cycle: mem_read=0 and mem_write=1; mem_out SHALL be captured at the closing rising edge; rf_wen=1 with the captured rf_wdata and rf_waddr=i in the following cycle.
REQ-022 Store XFER cycle: mem_write=0 and mem_read=1; mem_in = rf_rdata combinationally; rf_wen=0.
REQ-023 Throughput SHALL be one transfer per cycle; N set bits SHALL give N XFER cycles; no idle cycle between transfers.
REQ-024 Transition XFER to FIN SHALL occur after the last set bit is serviced; FIN lasts one cycle with done=1, then returns to IDLE.
REQ-025 For load, the final rf_wen SHALL coincide with the FIN cycle.
REQ-026 Outside XFER, mem_read=1 and mem_write=1; the two strobes SHALL never be low together.
REQ-027 start while not in IDLE SHALL be ignored; start in the FIN cycle SHALL be ignored.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_W (31 + 1 = 0) unless SEQ_WRAP_ERR_EN is defined.

Reset
REQ-029 With proc_rst=0 at a rising edge, the FSM SHALL enter IDLE and set busy=0, done=0, err=0, rf_wen=0, mem_read=1, mem_write=1, mem_addr=0, mem_in=0, rf_wdata=0, rf_raddr=0 and rf_waddr=0.
REQ-030 Reset during XFER SHALL abort the burst; no strobe or rf_wen SHALL be asserted in the cycle after the reset edge.

Configuration
REQ-031 Macro SEQ_WRAP_ERR_EN defined: a transfer whose address would advance past 2^ADDR_W-1 with mask bits remaining SHALL complete the current transfer, skip the remaining bits, go to FIN, and set err=1 until the next accepted start.
REQ-032 Macro SEQ_WRAP_ERR_EN undefined: the address SHALL wrap to 0, and err SHALL be tied to 0.

Verification
REQ-033 Load: base 2, mask 8'hFF, memory[2..9] = 1..8 -> 8 XFER cycles; rf writes r0..r7 = 1..8; done 9 cycles after start.
REQ-034 Store: base 20, mask 8'b1000_0101, r0=AAAA, r2=5555, r7=1234 -> mem[20]=AAAA, mem[21]=5555, mem[22]=1234; 3 write strobes.
REQ-035 Empty mask -> no strobe and no rf_wen; done in the cycle after start.
REQ-036 Wrap: base 30, mask 8'h0F -> without the macro, addresses 30, 31, 0, 1 and err=0; with the macro, addresses 30 and 31 only, then done and err=1.
REQ-037 proc_rst=0 during the third load transfer -> strobes high next cycle, no further rf_wen, busy=0; a new start is then accepted normally.
